gpu_tile_writer: RTL and testbench
==================================

# gpu_tile_writer

Parametrised pixel write-out engine for one render tile, successor to the single-byte WRITEOUT/WRITE path of the GPU controller. After shading finishes, it gathers the tile's shaded pixels from the shader array one pixel per cycle and packs them into bus-width beats. It writes each beat to the framebuffer at the tile's position, using a row stride of TOTAL_COLS and per-pixel byte enables, so pixels no ray hit are left untouched. When the tile is complete it raises a level interrupt and holds it until it is cleared.

## Interface
Parameters:
- MY_ROWS, 4, tile height in pixels
- MY_COLS, 4, tile width in pixels; multiple of PPB
- TOTAL_ROWS, 240, framebuffer height
- TOTAL_COLS, 320, framebuffer width (row stride in pixels)
- ROW_BITS, $clog2(TOTAL_ROWS), row index width
- COL_BITS, $clog2(TOTAL_COLS), column index width
- PIXEL_BITS, 16, pixel width; multiple of 8; divides BUS_BYTES*8
- BUS_BYTES, 4, master data width in bytes; PPB = BUS_BYTES*8/PIXEL_BITS pixels per beat
- SKIP_EMPTY, 1, 1 = beats with no hit pixel are not issued

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; honoured only in IDLE
- start_row  in  ROW_BITS  tile origin row; sampled on accepted start
- start_col  in  COL_BITS  tile origin column; multiple of PPB; sampled on accepted start
- pixel_buffer  in  32  framebuffer base byte address; BUS_BYTES-aligned; sampled on accepted start
- sel_row  out  $clog2(MY_ROWS)  local row of the pixel being gathered
- sel_col  out  $clog2(MY_COLS)  local column of the pixel being gathered
- pixel  in  PIXEL_BITS  shader colour for sel_row/sel_col; combinational, same cycle
- pixel_hit  in  1  1 = that shader produced a colour
- m1_address  out  32  beat byte address
- m1_writedata  out  BUS_BYTES*8  packed pixels; lowest column in the lowest lanes
- m1_byteenable  out  BUS_BYTES  per-byte enable
- m1_write  out  1  write request
- m1_waitrequest  in  1  Avalon-MM stall
- busy  out  1  high in any state other than IDLE
- irq  out  1  tile complete; level signal
- clear_interrupt  in  1  acknowledges irq

## Operation
- States: IDLE, GATHER, WRITE, INTERRUPT.
- IDLE: start=1 latches the origin and base address, clears r, c and the lane counter, and moves to GATHER.
- GATHER: each cycle sel_row=r, sel_col=c+lane.
  - pixel is stored into lane `lane`. Each of that lane's PIXEL_BITS/8 byteenable bits is set to pixel_hit.
  - On the cycle with lane==PPB-1, the beat address is latched: pixel_buffer + ((start_row+r)*TOTAL_COLS + start_col + c)*(PIXEL_BITS/8), computed at 32 bits and wrapping modulo 2^32.
  - At the end of that cycle the next state is WRITE. If SKIP_EMPTY=1 and all enables are 0, the beat is skipped instead, as if it had been accepted.
- WRITE: m1_write=1 with address, data and byteenable held stable until a cycle with m1_waitrequest=0.
  - On acceptance, c += PPB. When c wraps to 0, r += 1.
  - If the beat just accepted (or skipped) was the last one, at r=MY_ROWS-1 and c=MY_COLS-PPB, the next state is INTERRUPT; otherwise it is GATHER.
- INTERRUPT: irq=1. clear_interrupt=1 returns the block to IDLE.
- start outside IDLE is ignored. clear_interrupt outside INTERRUPT is ignored.
- A start in the same cycle as clear_interrupt in INTERRUPT is ignored: the block returns to IDLE only.
- Total beats per tile = MY_ROWS*MY_COLS/PPB.

## Timing
- Reset (reset_n=0, at any time, including mid-write): state=IDLE and every output is 0, namely m1_address, m1_writedata, m1_byteenable, m1_write, sel_row, sel_col, busy and irq. An in-flight write is dropped.
- Outputs are registered except sel_row and sel_col, which decode the state registers.
- Latency from start to the first m1_write: PPB+1 cycles. Each further beat costs PPB gather cycles plus WRITE cycles (1 plus the number of waitrequest cycles).
- m1_write never deasserts while m1_waitrequest=1.
- A skipped beat costs only its gather cycles.
- irq rises on the cycle after the last beat is accepted or skipped.

## Test plan
- Defaults, start_row=2, start_col=8, pixel_buffer=0x1000, all hits, waitrequest=0 -> 8 writes.
  - First write: address 0x1000+(2*320+8)*2=0x1510, byteenable 0xF.
  - Row 1: address 0x1790.
  - irq rises at cycle 8*3+1 after start.
- Pixels 0xAAAA and 0xBBBB at local columns 0 and 1, with column 1 not hit -> writedata 0xBBBBAAAA, byteenable 0x3.
- SKIP_EMPTY=1 with row 1 all misses -> only 6 writes are issued, and addresses 0x1790 and 0x1794 never appear.
- waitrequest held high for 5 cycles on the second beat -> m1_write, address, data and byteenable are stable for all 6 cycles, and no beat is duplicated or lost.
- Assert reset_n=0 in the middle of WRITE, then start again -> all outputs are 0 during reset, and the full 8-beat sequence restarts from 0x1510.
- In INTERRUPT, hold start=1 for 3 cycles, then pulse clear_interrupt -> irq stays 1 until the clear, the state goes to IDLE, and there is no write activity.

Source files
------------

// File: rtl/gpu_tile_writer.sv
// Gathers a render tile's shaded pixels one per cycle, packs them into bus beats and writes them to the framebuffer.
// First write PPB+1 cycles after start; a beat is held on the master port until m1_waitrequest drops.
module gpu_tile_writer #(
  parameter int MY_ROWS    = 4,
  parameter int MY_COLS    = 4,
  parameter int TOTAL_ROWS = 240,
  parameter int TOTAL_COLS = 320,
  parameter int ROW_BITS   = $clog2(TOTAL_ROWS),
  parameter int COL_BITS   = $clog2(TOTAL_COLS),
  parameter int PIXEL_BITS = 16,
  parameter int BUS_BYTES  = 4,
  parameter int SKIP_EMPTY = 1,
  localparam int SRW       = (MY_ROWS > 1) ? $clog2(MY_ROWS) : 1,
  localparam int SCW       = (MY_COLS > 1) ? $clog2(MY_COLS) : 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ROW_BITS-1:0]    start_row,
  input  logic [COL_BITS-1:0]    start_col,
  input  logic [31:0]            pixel_buffer,
  output logic [SRW-1:0]         sel_row,
  output logic [SCW-1:0]         sel_col,
  input  logic [PIXEL_BITS-1:0]  pixel,
  input  logic                   pixel_hit,
  output logic [31:0]            m1_address,
  output logic [BUS_BYTES*8-1:0] m1_writedata,
  output logic [BUS_BYTES-1:0]   m1_byteenable,
  output logic                   m1_write,
  input  logic                   m1_waitrequest,
  output logic                   busy,
  output logic                   irq,
  input  logic                   clear_interrupt
);

  localparam int PPB = BUS_BYTES * 8 / PIXEL_BITS;
  localparam int BPP = PIXEL_BITS / 8;
  localparam int LW  = (PPB > 1) ? $clog2(PPB) : 1;
  localparam int DW  = BUS_BYTES * 8;

  typedef enum logic [1:0] {IDLE, GATHER, WRITE, INTERRUPT} state_t;

  state_t                state_q, state_d;
  logic [SRW-1:0]        r_q, r_d;
  logic [SCW-1:0]        c_q, c_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [ROW_BITS-1:0]   org_row_q, org_row_d;
  logic [COL_BITS-1:0]   org_col_q, org_col_d;
  logic [31:0]           base_q, base_d;
  logic [31:0]           addr_q, addr_d;
  logic [DW-1:0]         data_q, data_d;
  logic [BUS_BYTES-1:0]  be_q, be_d;
  logic                  write_q, write_d;
  logic                  busy_q, busy_d;
  logic                  irq_q, irq_d;

  logic [31:0]           beat_addr;
  logic                  last_beat;
  logic                  beat_done;
  logic [SRW-1:0]        r_adv;
  logic [SCW-1:0]        c_adv;

  always_comb begin
    beat_addr = base_q + ((32'(org_row_q) + 32'(r_q)) * 32'(TOTAL_COLS)
                          + 32'(org_col_q) + 32'(c_q)) * 32'(BPP);
    last_beat = (int'(r_q) == MY_ROWS - 1) && (int'(c_q) == MY_COLS - PPB);
    if (int'(c_q) + PPB >= MY_COLS) begin
      c_adv = '0;
      r_adv = r_q + SRW'(1);
    end else begin
      c_adv = c_q + SCW'(PPB);
      r_adv = r_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    c_d       = c_q;
    lane_d    = lane_q;
    org_row_d = org_row_q;
    org_col_d = org_col_q;
    base_d    = base_q;
    addr_d    = addr_q;
    data_d    = data_q;
    be_d      = be_q;
    write_d   = write_q;
    busy_d    = busy_q;
    irq_d     = irq_q;
    beat_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          org_row_d = start_row;
          org_col_d = start_col;
          base_d    = pixel_buffer;
          r_d       = '0;
          c_d       = '0;
          lane_d    = '0;
          busy_d    = 1'b1;
          state_d   = GATHER;
        end
      end
      GATHER: begin
        for (int i = 0; i < PPB; i++) begin
          if (lane_q == LW'(i)) begin
            data_d[i*PIXEL_BITS +: PIXEL_BITS] = pixel;
            be_d[i*BPP +: BPP]                 = {BPP{pixel_hit}};
          end
        end
        if (int'(lane_q) == PPB - 1) begin
          lane_d = '0;
          addr_d = beat_addr;
          // An all-miss beat advances the tile position exactly like an accepted write.
          if ((SKIP_EMPTY != 0) && (be_d == '0)) begin
            beat_done = 1'b1;
          end else begin
            write_d = 1'b1;
            state_d = WRITE;
          end
        end else begin
          lane_d = lane_q + LW'(1);
        end
      end
      WRITE: begin
        if (!m1_waitrequest) begin
          write_d   = 1'b0;
          beat_done = 1'b1;
        end
      end
      INTERRUPT: begin
        if (clear_interrupt) begin
          irq_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (beat_done) begin
      c_d = c_adv;
      r_d = r_adv;
      if (last_beat) begin
        irq_d   = 1'b1;
        state_d = INTERRUPT;
      end else begin
        state_d = GATHER;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      r_q       <= '0;
      c_q       <= '0;
      lane_q    <= '0;
      org_row_q <= '0;
      org_col_q <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      be_q      <= '0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      c_q       <= c_d;
      lane_q    <= lane_d;
      org_row_q <= org_row_d;
      org_col_q <= org_col_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      be_q      <= be_d;
      write_q   <= write_d;
      busy_q    <= busy_d;
      irq_q     <= irq_d;
    end
  end

  assign sel_row       = (state_q == GATHER) ? r_q : '0;
  assign sel_col       = (state_q == GATHER) ? (c_q + SCW'(lane_q)) : '0;
  assign m1_address    = addr_q;
  assign m1_writedata  = data_q;
  assign m1_byteenable = be_q;
  assign m1_write      = write_q;
  assign busy          = busy_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_gpu_tile_writer.sv
// Bench for gpu_tile_writer at default parameters: table of tile runs, scoreboard of expected beats, corner sequences.
module tb_gpu_tile_writer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  start_row = '0;
  logic [8:0]  start_col = '0;
  logic [31:0] pixel_buffer = '0;
  logic [1:0]  sel_row, sel_col;
  logic [15:0] pixel;
  logic        pixel_hit;
  logic [31:0] m1_address, m1_writedata;
  logic [3:0]  m1_byteenable;
  logic        m1_write;
  logic        m1_waitrequest = 1'b0;
  logic        busy, irq;
  logic        clear_interrupt = 1'b0;

  always #5 clock = ~clock;

  gpu_tile_writer dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .start_row(start_row), .start_col(start_col), .pixel_buffer(pixel_buffer),
    .sel_row(sel_row), .sel_col(sel_col), .pixel(pixel), .pixel_hit(pixel_hit),
    .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_write(m1_write), .m1_waitrequest(m1_waitrequest),
    .busy(busy), .irq(irq), .clear_interrupt(clear_interrupt)
  );

  // Shader array model: per-test colour table and hit mask indexed by {row, col}.
  logic [15:0] pix_tab [16];
  logic [15:0] hit_mask = '0;
  assign pixel     = pix_tab[{sel_row, sel_col}];
  assign pixel_hit = hit_mask[{sel_row, sel_col}];

  typedef struct {
    int          srow;
    int          scol;
    logic [31:0] base;
    logic [15:0] hm;
    bit          aabb;
    int          wait_beat;
    int          wait_len;
    int          exp_writes;
    int          exp_irq;
    int          exp_lat;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
  } tvec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } beat_t;

  tvec_t       vec [8];
  beat_t       exp_q [$];
  logic [31:0] wr_addrs [$];

  int npass = 0, nchk = 0;
  int cyc = 0, start_cyc = 0;
  int beat_idx = 0, wcnt = 0, wait_beat = -1, wait_len = 0, nwr = 0;
  int first_lat = 0;
  logic [31:0] first_addr = '0, first_data = '0;
  logic [3:0]  first_be = '0;
  bit          stalled = 1'b0;
  logic [31:0] h_addr = '0, h_data = '0;
  logic [3:0]  h_be = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(posedge clock) cyc++;

  // Bus slave: inserts wait states, checks that stalled beats hold still, scores accepted beats.
  always @(negedge clock) begin
    if (!reset_n) begin
      m1_waitrequest = 1'b0;
      stalled        = 1'b0;
      wcnt           = 0;
    end else begin
      if (stalled)
        chk("stall_hold", {m1_write, m1_address, m1_writedata, m1_byteenable},
            {1'b1, h_addr, h_data, h_be});
      if (m1_write) begin
        if (beat_idx == wait_beat && wcnt < wait_len) begin
          m1_waitrequest = 1'b1;
          stalled        = 1'b1;
          wcnt++;
          h_addr = m1_address;
          h_data = m1_writedata;
          h_be   = m1_byteenable;
        end else begin
          beat_t e;
          e = '0;
          m1_waitrequest = 1'b0;
          stalled        = 1'b0;
          wcnt           = 0;
          beat_idx++;
          nwr++;
          wr_addrs.push_back(m1_address);
          if (nwr == 1) begin
            first_lat  = cyc - start_cyc + 1;
            first_addr = m1_address;
            first_data = m1_writedata;
            first_be   = m1_byteenable;
          end
          if (exp_q.size() > 0) e = exp_q.pop_front();
          chk("beat", {m1_address, m1_writedata, m1_byteenable}, e);
        end
      end else begin
        m1_waitrequest = 1'b0;
        stalled        = 1'b0;
      end
    end
  end

  // Loads the shader model, pushes the expected beats, and pulses start (called at #1 after a posedge).
  task automatic kick(input tvec_t v, input int vi);
    logic [3:0] be;
    beat_t e;
    for (int i = 0; i < 16; i++) pix_tab[i] = {8'(vi), 4'(i / 4), 4'(i % 4)};
    if (v.aabb) begin
      pix_tab[0] = 16'hAAAA;
      pix_tab[1] = 16'hBBBB;
    end
    hit_mask  = v.hm;
    wait_beat = v.wait_beat;
    wait_len  = v.wait_len;
    beat_idx  = 0;
    nwr       = 0;
    first_lat = 0;
    wr_addrs.delete();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c += 2) begin
        be = {{2{v.hm[r*4+c+1]}}, {2{v.hm[r*4+c]}}};
        if (be != 4'h0) begin
          e.addr = v.base + ((32'(v.srow) + 32'(r)) * 32'd320 + 32'(v.scol) + 32'(c)) * 32'd2;
          e.data = {pix_tab[r*4+c+1], pix_tab[r*4+c]};
          e.be   = be;
          exp_q.push_back(e);
        end
      end
    end
    start_row    = 8'(v.srow);
    start_col    = 9'(v.scol);
    pixel_buffer = v.base;
    start        = 1'b1;
    @(posedge clock);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic run_tile(input tvec_t v, input int vi, input bit do_clear);
    int irq_cyc;
    kick(v, vi);
    while (!irq && (cyc - start_cyc) < 300) begin
      @(posedge clock);
      #1;
    end
    irq_cyc = cyc - start_cyc + 1;
    chk($sformatf("v%0d_irq_cycle", vi), 128'(irq_cyc), 128'(v.exp_irq));
    chk($sformatf("v%0d_write_count", vi), 128'(nwr), 128'(v.exp_writes));
    chk($sformatf("v%0d_beats_left", vi), 128'(exp_q.size()), 128'(0));
    if (v.exp_lat > 0) begin
      chk($sformatf("v%0d_first_latency", vi), 128'(first_lat), 128'(v.exp_lat));
      chk($sformatf("v%0d_first_beat", vi), {first_addr, first_data, first_be},
          {v.exp_addr, v.exp_data, v.exp_be});
    end
    if (do_clear) begin
      clear_interrupt = 1'b1;
      @(posedge clock);
      #1;
      clear_interrupt = 1'b0;
      chk($sformatf("v%0d_cleared", vi), {irq, busy}, 2'b00);
    end
  endtask

  initial begin
    tvec_t t;
    int n, bad, nw0;
    //        srow scol base           hm        aabb wb  wl wr irq lat addr           data           be
    vec[0] = '{2,   8,   32'h1000,      16'hFFFF, 0,  -1, 0, 8, 25, 3, 32'h1510,      32'h0001_0000, 4'hF};
    vec[1] = '{2,   8,   32'h1000,      16'hFF0F, 0,  -1, 0, 6, 23, 3, 32'h1510,      32'h0101_0100, 4'hF};
    vec[2] = '{2,   8,   32'h1000,      16'hFFFF, 0,   1, 5, 8, 30, 3, 32'h1510,      32'h0201_0200, 4'hF};
    vec[3] = '{0,   0,   32'h0,         16'h5555, 0,  -1, 0, 8, 25, 3, 32'h0,         32'h0301_0300, 4'h3};
    vec[4] = '{0,   0,   32'hFFFF_FFF0, 16'hFFFF, 0,  -1, 0, 8, 25, 3, 32'hFFFF_FFF0, 32'h0401_0400, 4'hF};
    vec[5] = '{2,   8,   32'h1000,      16'h0000, 0,  -1, 0, 0, 17, 0, 32'h0,         32'h0,         4'h0};
    vec[6] = '{1,   2,   32'h2000,      16'hFFFD, 1,  -1, 0, 8, 25, 3, 32'h2284,      32'hBBBB_AAAA, 4'h3};
    vec[7] = '{239, 316, 32'h0,         16'hFFFF, 0,  -1, 0, 8, 25, 3, 32'h0002_57F8, 32'h0701_0700, 4'hF};
    for (int i = 0; i < 16; i++) pix_tab[i] = '0;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", {m1_address, m1_writedata, m1_byteenable, m1_write, sel_row, sel_col, busy, irq}, '0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_tile(vec[i], i, 1'b1);
      if (i == 0) chk("row1_address", (wr_addrs.size() > 2) ? wr_addrs[2] : 32'h0, 32'h1790);
      if (i == 1) begin
        bad = 0;
        foreach (wr_addrs[k]) if (wr_addrs[k] == 32'h1790 || wr_addrs[k] == 32'h1794) bad++;
        chk("skipped_addrs_absent", 128'(bad), 128'(0));
      end
    end

    // Reset while the third beat is stalled on the bus, then a clean restart.
    t = vec[0];
    t.wait_beat = 2;
    t.wait_len  = 1000;
    kick(t, 0);
    n = 0;
    while (!(stalled && beat_idx == 2) && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("reached_stall", {m1_write, 8'(beat_idx)}, {1'b1, 8'd2});
    reset_n = 1'b0;
    #2;
    chk("midwrite_reset_outputs", {m1_address, m1_writedata, m1_byteenable, m1_write, sel_row, sel_col, busy, irq}, '0);
    @(posedge clock);
    #1;
    chk("held_reset_outputs", {m1_address, m1_writedata, m1_byteenable, m1_write, sel_row, sel_col, busy, irq}, '0);
    exp_q.delete();
    wait_len = 0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    run_tile(vec[0], 0, 1'b1);

    // start held in INTERRUPT is ignored, including on the clearing cycle.
    run_tile(vec[0], 0, 1'b0);
    nw0          = nwr;
    start_row    = 8'd2;
    start_col    = 9'd8;
    pixel_buffer = 32'h1000;
    start        = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      chk($sformatf("int_hold_%0d", k), {irq, busy}, 2'b11);
    end
    clear_interrupt = 1'b1;
    @(posedge clock);
    #1;
    clear_interrupt = 1'b0;
    start           = 1'b0;
    chk("int_cleared", {irq, busy}, 2'b00);
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    chk("idle_after_clear", {busy, m1_write, 8'(nwr - nw0)}, 10'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
